// File: rtl/core_mem_llsc_unit.sv
// Memory-stage load/store responder: single-beat req/ack data-memory access,
// pipeline stall while busy, and the per-core LL/SC link reservation.
module core_mem_llsc_unit #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              ex_mem_memread,
  input  logic              ex_mem_memwrite,
  input  logic              ex_mem_ll,
  input  logic              ex_mem_sc,
  input  logic [ADDR_W-1:0] ex_mem_addr,
  input  logic [DATA_W-1:0] ex_mem_wdata,
  output logic              mem_stall,
  output logic [DATA_W-1:0] mem_rdata,
  output logic              mem_rdata_valid,
  output logic              dmem_req,
  output logic              dmem_we,
  output logic [ADDR_W-1:0] dmem_addr,
  output logic [DATA_W-1:0] dmem_wdata,
  input  logic              dmem_ack,
  input  logic [DATA_W-1:0] dmem_rdata,
  input  logic              snoop_inv_valid,
  input  logic [ADDR_W-1:0] snoop_inv_addr,
  output logic              link_valid,
  output logic [ADDR_W-1:0] link_addr
);

  typedef enum logic [1:0] {IDLE, REQ, DONE} state_e;

  state_e            state_q, state_d;
  logic              dmem_req_q, dmem_req_d;
  logic              dmem_we_q, dmem_we_d;
  logic [ADDR_W-1:0] dmem_addr_q, dmem_addr_d;
  logic [DATA_W-1:0] dmem_wdata_q, dmem_wdata_d;
  logic              op_ld_q, op_ld_d;
  logic              op_ll_q, op_ll_d;
  logic              op_sc_q, op_sc_d;
  logic [DATA_W-1:0] mem_rdata_q, mem_rdata_d;
  logic              link_valid_q, link_valid_d;
  logic [ADDR_W-1:0] link_addr_q, link_addr_d;

  logic req, is_load, is_ll, is_sc, link_hit, sw_hit;
  logic snoop_lsb_unused;

  // Load wins when both read and write are asserted; ll/sc only qualify their own kind.
  assign req      = ex_mem_memread | ex_mem_memwrite;
  assign is_load  = ex_mem_memread;
  assign is_ll    = ex_mem_memread & ex_mem_ll;
  assign is_sc    = ex_mem_memwrite & ~ex_mem_memread & ex_mem_sc;
  assign link_hit = link_valid_q &&
                    (link_addr_q[ADDR_W-1:2] == ex_mem_addr[ADDR_W-1:2]);
  assign sw_hit   = link_valid_q &&
                    (link_addr_q[ADDR_W-1:2] == dmem_addr_q[ADDR_W-1:2]);
  assign snoop_lsb_unused = ^snoop_inv_addr[1:0];

  always_comb begin
    state_d      = state_q;
    dmem_req_d   = dmem_req_q;
    dmem_we_d    = dmem_we_q;
    dmem_addr_d  = dmem_addr_q;
    dmem_wdata_d = dmem_wdata_q;
    op_ld_d      = op_ld_q;
    op_ll_d      = op_ll_q;
    op_sc_d      = op_sc_q;
    mem_rdata_d  = mem_rdata_q;
    link_valid_d = link_valid_q;
    link_addr_d  = link_addr_q;
    case (state_q)
      IDLE: begin
        if (req) begin
          if (is_sc && !link_hit) begin
            // Failed sc resolves locally: no memory traffic.
            state_d      = DONE;
            mem_rdata_d  = '0;
            link_valid_d = 1'b0;
          end else begin
            state_d      = REQ;
            dmem_req_d   = 1'b1;
            dmem_we_d    = ex_mem_memwrite & ~ex_mem_memread;
            dmem_addr_d  = ex_mem_addr;
            dmem_wdata_d = ex_mem_wdata;
            op_ld_d      = is_load;
            op_ll_d      = is_ll;
            op_sc_d      = is_sc;
          end
        end
      end
      REQ: begin
        if (dmem_ack) begin
          state_d    = DONE;
          dmem_req_d = 1'b0;
          if (op_ld_q)      mem_rdata_d = dmem_rdata;
          else if (op_sc_q) mem_rdata_d = DATA_W'(1);
          if (op_ll_q) begin
            link_valid_d = 1'b1;
            link_addr_d  = dmem_addr_q;
          end else if (op_sc_q) begin
            link_valid_d = 1'b0;
          end else if (!op_ld_q && sw_hit) begin
            link_valid_d = 1'b0;
          end
        end
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
    // Compared against the post-update link so a same-cycle ll completion still loses.
    if (snoop_inv_valid &&
        (snoop_inv_addr[ADDR_W-1:2] == link_addr_d[ADDR_W-1:2]))
      link_valid_d = 1'b0;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= IDLE;
      dmem_req_q   <= 1'b0;
      dmem_we_q    <= 1'b0;
      dmem_addr_q  <= '0;
      dmem_wdata_q <= '0;
      op_ld_q      <= 1'b0;
      op_ll_q      <= 1'b0;
      op_sc_q      <= 1'b0;
      mem_rdata_q  <= '0;
      link_valid_q <= 1'b0;
      link_addr_q  <= '0;
    end else begin
      state_q      <= state_d;
      dmem_req_q   <= dmem_req_d;
      dmem_we_q    <= dmem_we_d;
      dmem_addr_q  <= dmem_addr_d;
      dmem_wdata_q <= dmem_wdata_d;
      op_ld_q      <= op_ld_d;
      op_ll_q      <= op_ll_d;
      op_sc_q      <= op_sc_d;
      mem_rdata_q  <= mem_rdata_d;
      link_valid_q <= link_valid_d;
      link_addr_q  <= link_addr_d;
    end
  end

  assign mem_stall       = ((state_q == IDLE) && req) || (state_q == REQ);
  assign mem_rdata       = mem_rdata_q;
  assign mem_rdata_valid = (state_q == DONE);
  assign dmem_req        = dmem_req_q;
  assign dmem_we         = dmem_we_q;
  assign dmem_addr       = dmem_addr_q;
  assign dmem_wdata      = dmem_wdata_q;
  assign link_valid      = link_valid_q;
  assign link_addr       = link_addr_q;

endmodule

// File: tb/tb_core_mem_llsc_unit.sv
// Directed bench for core_mem_llsc_unit: expected responses queued at issue,
// popped and compared on each mem_rdata_valid pulse.
module tb_core_mem_llsc_unit;
  localparam int AW = 32;
  localparam int DW = 32;

  logic          clk = 1'b0;
  logic          rst;
  logic          ex_mem_memread, ex_mem_memwrite, ex_mem_ll, ex_mem_sc;
  logic [AW-1:0] ex_mem_addr;
  logic [DW-1:0] ex_mem_wdata;
  logic          mem_stall, mem_rdata_valid, dmem_req, dmem_we, dmem_ack;
  logic [DW-1:0] mem_rdata, dmem_wdata, dmem_rdata;
  logic [AW-1:0] dmem_addr, snoop_inv_addr, link_addr;
  logic          snoop_inv_valid, link_valid;

  int checks = 0;
  int errors = 0;
  int pulses = 0;
  logic [DW-1:0] sb[$];

  core_mem_llsc_unit #(.ADDR_W(AW), .DATA_W(DW)) dut (
    .clk(clk), .rst(rst),
    .ex_mem_memread(ex_mem_memread), .ex_mem_memwrite(ex_mem_memwrite),
    .ex_mem_ll(ex_mem_ll), .ex_mem_sc(ex_mem_sc),
    .ex_mem_addr(ex_mem_addr), .ex_mem_wdata(ex_mem_wdata),
    .mem_stall(mem_stall), .mem_rdata(mem_rdata), .mem_rdata_valid(mem_rdata_valid),
    .dmem_req(dmem_req), .dmem_we(dmem_we), .dmem_addr(dmem_addr),
    .dmem_wdata(dmem_wdata), .dmem_ack(dmem_ack), .dmem_rdata(dmem_rdata),
    .snoop_inv_valid(snoop_inv_valid), .snoop_inv_addr(snoop_inv_addr),
    .link_valid(link_valid), .link_addr(link_addr)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Response scoreboard
  always @(negedge clk) begin
    if (mem_rdata_valid === 1'b1) begin
      pulses++;
      if (sb.size() == 0) chk("unexpected_resp", 64'(mem_rdata), 64'hBAD);
      else chk("resp_data", 64'(mem_rdata), 64'(sb.pop_front()));
    end
  end

  task automatic idle_inputs();
    ex_mem_memread = 0; ex_mem_memwrite = 0; ex_mem_ll = 0; ex_mem_sc = 0;
    ex_mem_addr = '0; ex_mem_wdata = '0;
  endtask

  // Called at posedge+1 with the unit IDLE; returns at posedge+1 after DONE.
  task automatic run_op(input logic rd, input logic wr, input logic ll, input logic sc,
                        input logic [AW-1:0] addr, input logic [DW-1:0] wdata,
                        input bit access, input int lat, input logic [DW-1:0] rdat,
                        input bit snp, input logic [DW-1:0] exp);
    ex_mem_memread = rd; ex_mem_memwrite = wr; ex_mem_ll = ll; ex_mem_sc = sc;
    ex_mem_addr = addr; ex_mem_wdata = wdata;
    sb.push_back(exp);
    @(negedge clk);
    chk("idle_stall", 64'(mem_stall), 64'd1);
    chk("idle_noreq", 64'(dmem_req), 64'd0);
    if (access) begin
      for (int i = 1; i <= lat; i++) begin
        @(posedge clk); #1;
        dmem_ack = (i == lat);
        dmem_rdata = (i == lat) ? rdat : 32'h0BAD_0BAD;
        if (snp && i == lat) begin snoop_inv_valid = 1; snoop_inv_addr = addr; end
        @(negedge clk);
        chk("req_high", 64'(dmem_req), 64'd1);
        chk("req_stall", 64'(mem_stall), 64'd1);
        chk("req_addr", 64'(dmem_addr), 64'(addr));
        chk("req_we", 64'(dmem_we), 64'(wr & ~rd));
        if (wr & ~rd) chk("req_wdata", 64'(dmem_wdata), 64'(wdata));
      end
      @(posedge clk); #1;
      dmem_ack = 0; snoop_inv_valid = 0;
    end else begin
      @(posedge clk); #1;
    end
    @(negedge clk);
    chk("done_valid", 64'(mem_rdata_valid), 64'd1);
    chk("done_stall", 64'(mem_stall), 64'd0);
    chk("done_noreq", 64'(dmem_req), 64'd0);
    @(posedge clk); #1;
    idle_inputs();
  endtask

  task automatic snoop(input logic [AW-1:0] a);
    snoop_inv_valid = 1; snoop_inv_addr = a;
    @(posedge clk); #1;
    snoop_inv_valid = 0;
  endtask

  task automatic link_chk(input string tag, input logic v);
    @(negedge clk);
    chk(tag, 64'(link_valid), 64'(v));
    @(posedge clk); #1;
  endtask

  initial begin
    int p0;
    rst = 1; idle_inputs();
    dmem_ack = 0; dmem_rdata = '0; snoop_inv_valid = 0; snoop_inv_addr = '0;
    repeat (2) @(posedge clk);
    #1 rst = 0;
    @(negedge clk);
    chk("rst_stall", 64'(mem_stall), 0);
    chk("rst_valid", 64'(mem_rdata_valid), 0);
    chk("rst_rdata", 64'(mem_rdata), 0);
    chk("rst_req", 64'(dmem_req), 0);
    chk("rst_link", 64'(link_valid), 0);
    chk("rst_linkaddr", 64'(link_addr), 0);
    @(posedge clk); #1;

    // lw with three-cycle ack latency
    run_op(1, 0, 0, 0, 32'h100, 0, 1, 3, 32'hDEADBEEF, 0, 32'hDEADBEEF);
    repeat (2) @(posedge clk); #1;
    @(negedge clk); chk("rdata_hold", 64'(mem_rdata), 64'hDEADBEEF);
    @(posedge clk); #1;

    // ll then successful sc
    run_op(1, 0, 1, 0, 32'h200, 0, 1, 1, 32'h11, 0, 32'h11);
    @(negedge clk);
    chk("ll_link", 64'(link_valid), 1);
    chk("ll_linkaddr", 64'(link_addr), 64'h200);
    @(posedge clk); #1;
    run_op(0, 1, 0, 1, 32'h200, 32'h5, 1, 1, 0, 0, 32'h1);
    link_chk("sc_ok_clears", 0);

    // ll, snoop same word, sc fails without memory access
    run_op(1, 0, 1, 0, 32'h200, 0, 1, 2, 32'h22, 0, 32'h22);
    snoop(32'h202);
    link_chk("snoop_clear", 0);
    run_op(0, 1, 0, 1, 32'h200, 32'h5, 0, 0, 0, 0, 32'h0);

    // snoop coincident with ll ack wins
    run_op(1, 0, 1, 0, 32'h300, 0, 1, 2, 32'h33, 1, 32'h33);
    link_chk("snoop_wins", 0);

    // sw to another word keeps link; sc succeeds
    run_op(1, 0, 1, 0, 32'h400, 0, 1, 1, 32'h44, 0, 32'h44);
    run_op(0, 1, 0, 0, 32'h404, 32'h7, 1, 2, 0, 0, 32'h44);
    link_chk("sw_other_keeps", 1);
    run_op(0, 1, 0, 1, 32'h400, 32'h9, 1, 1, 0, 0, 32'h1);
    link_chk("sc2_clears", 0);

    // sw to linked word kills link; sc fails
    run_op(1, 0, 1, 0, 32'h400, 0, 1, 1, 32'h55, 0, 32'h55);
    run_op(0, 1, 0, 0, 32'h400, 32'h8, 1, 1, 0, 0, 32'h55);
    link_chk("sw_same_clears", 0);
    run_op(0, 1, 0, 1, 32'h400, 32'h9, 0, 0, 0, 0, 32'h0);

    // read+write together is a load; sc flag with memread ignored
    run_op(1, 1, 0, 1, 32'h600, 32'hAA, 1, 1, 32'h66, 0, 32'h66);

    // reset in the middle of an access
    run_op(1, 0, 1, 0, 32'h700, 0, 1, 1, 32'h77, 0, 32'h77);
    ex_mem_memread = 1; ex_mem_addr = 32'h500;
    @(posedge clk); #1;
    @(negedge clk); chk("pre_rst_req", 64'(dmem_req), 1);
    @(posedge clk); #1;
    p0 = pulses;
    rst = 1; idle_inputs();
    @(posedge clk); #1;
    rst = 0;
    @(negedge clk);
    chk("rst_mid_req", 64'(dmem_req), 0);
    chk("rst_mid_link", 64'(link_valid), 0);
    @(posedge clk); #1;
    dmem_ack = 1; dmem_rdata = 32'h12345678;
    @(posedge clk); #1;
    dmem_ack = 0;
    repeat (3) @(posedge clk); #1;
    @(negedge clk);
    chk("rst_no_pulse", 64'(pulses - p0), 0);
    chk("rst_idle_stall", 64'(mem_stall), 0);
    chk("rst_idle_req", 64'(dmem_req), 0);
    chk("sb_drained", 64'(sb.size()), 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    errors++;
    $display("FAIL timeout: simulation did not complete, observed running expected finished");
    $fatal(1, "timeout");
  end
endmodule

// File: doc/core_mem_llsc_unit.md
Name: core_mem_llsc_unit

Overview:
- Memory-stage responder for the load/store requests decoded in ID: lw, sw, ll and sc, carried through EX/MEM as memread, memwrite, ll_mem and sc_mem.
- Issues single-beat accesses to the data-memory/ring port using a req/ack handshake.
- Stalls the pipeline while an access is outstanding.
- Holds the per-core LL link reservation, which is cleared by ring invalidations from other cores.

Parameters:
ADDR_W, 32, byte address width
DATA_W, 32, data width

Ports:
clk  in  1  clock
rst  in  1  synchronous active-high reset
ex_mem_memread  in  1  load request (lw/ll)
ex_mem_memwrite  in  1  store request (sw/sc)
ex_mem_ll  in  1  qualifies memread as ll
ex_mem_sc  in  1  qualifies memwrite as sc
ex_mem_addr  in  ADDR_W  byte address from ALU
ex_mem_wdata  in  DATA_W  store data
mem_stall  out  1  freeze IF/ID/EX/MEM registers
mem_rdata  out  DATA_W  load data, or sc result {0…,success}
mem_rdata_valid  out  1  one-cycle response pulse
dmem_req  out  1  access request
dmem_we  out  1  1=write
dmem_addr  out  ADDR_W  access address
dmem_wdata  out  DATA_W  write data
dmem_ack  in  1  access complete
dmem_rdata  in  DATA_W  read data, valid with ack
snoop_inv_valid  in  1  remote-store invalidation from ring
snoop_inv_addr  in  ADDR_W  invalidated address
link_valid  out  1  reservation held
link_addr  out  ADDR_W  reserved address

Behaviour:
- Clock and reset: single clock clk; reset rst is synchronous and active-high.
- Reset values:
  - state IDLE
  - all outputs 0
  - link_valid 0, link_addr 0
  - Reset mid-access abandons it: dmem_req low the cycle after rst is sampled; no response pulse; any late dmem_ack is ignored.
- Request = ex_mem_memread | ex_mem_memwrite.
  - memread and memwrite both high: treated as a load.
  - ll with memwrite: ll ignored.
  - sc with memread: sc ignored.
- FSM states: IDLE, REQ, DONE.
- IDLE:
  - Request with sc and link miss (link_valid=0, or link_addr[ADDR_W-1:2] != ex_mem_addr[ADDR_W-1:2]):
    - no dmem access; go to DONE
    - response data 0; link cleared
  - Any other request:
    - register dmem_addr, dmem_wdata and dmem_we (=memwrite and not load-priority)
    - set dmem_req=1; go to REQ
- REQ:
  - dmem_req, dmem_we, dmem_addr and dmem_wdata are held stable until dmem_ack; ack is sampled only in REQ.
  - On ack: dmem_req=0; go to DONE.
  - Response data on ack:
    - load: dmem_rdata
    - sw: unchanged
    - sc: 1
- DONE (exactly 1 cycle):
  - mem_rdata_valid=1; mem_stall=0; request inputs ignored (same instruction still present)
  - next state IDLE
- mem_stall is combinational: (IDLE & request) | REQ.
  - Minimum latency with ack in the first REQ cycle: IDLE → REQ → DONE = 3 cycles, 2 stalled.
  - sc fail: 2 cycles, 1 stalled.
- mem_rdata is registered and holds its value between responses.
- Link updates:
  - ll completion sets link_valid=1 and link_addr=ex_mem_addr.
  - sc completion (success or fail) clears link_valid.
  - sw completion to the linked word clears link_valid.
- Snoop:
  - snoop_inv_valid with word-address match clears link_valid in any state.
  - Same-cycle snoop match and ll-ack: link ends invalid (snoop wins).
- sc outcome is decided at issue in IDLE; a snoop during the sc's REQ only clears the link, and the sc still returns 1.
- Word compare uses bits [ADDR_W-1:2].
- No request queueing; one outstanding access at most.

Test Plan:
- lw 0x100, ack after 3 REQ cycles with dmem_rdata=0xDEADBEEF → dmem_req high 3 cycles with addr 0x100 and we=0; mem_stall high 4 cycles; then mem_rdata_valid pulse with mem_rdata=0xDEADBEEF.
- ll 0x200, then sc 0x200 wdata 0x5 with immediate ack → link_valid=1 with link_addr=0x200 after ll; sc write issued with dmem_wdata=5; mem_rdata=1; link_valid=0.
- ll 0x200, snoop_inv 0x202, then sc 0x200 → no dmem_req for sc; mem_rdata=0 one cycle after issue; stall 1 cycle.
- ll 0x300 with snoop_inv 0x300 in the same cycle as ack → mem_rdata=load data; link_valid=0.
- ll 0x400, sw 0x404, sc 0x400 → link survives the sw (different word); sc succeeds with mem_rdata=1. Repeat with sw 0x400 → sc fails with mem_rdata=0 and no dmem access.
- lw in REQ, rst pulsed 1 cycle, then ack → dmem_req=0 the cycle after rst; no mem_rdata_valid; state IDLE; link_valid=0.
